// File: rtl/frogger_game_fsm_pkg.sv
// ---------------------------------------------------------------------------
// frogger_pkg
// Shared definitions for the Frogger game blocks: game state encoding,
// goal/score limits, frog origin tile, and saturating score/lives helpers.
// No ports (package).
// ---------------------------------------------------------------------------
package frogger_pkg;

    // Encoding is visible on o_State, so the values are fixed.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        P1_WINS = 2'b10,
        CLEANUP = 2'b11
    } t_game_state;

    localparam int c_GOAL_ROW_DEFAULT = 0;
    localparam int c_SCORE_MAX        = 99;

    // Tile where the frog (re)appears; shared with frogger_ctrl and
    // frogger_collisions.
    localparam int c_FROG_ORIGIN_X    = 10;
    localparam int c_FROG_ORIGIN_Y    = 14;

    localparam int c_CNT_W            = 8;

    function automatic logic [6:0] f_Score_Inc(input logic [6:0] i_Score);
        return (i_Score >= 7'(c_SCORE_MAX)) ? i_Score : i_Score + 7'd1;
    endfunction

    function automatic logic [1:0] f_Lives_Dec(input logic [1:0] i_Lives);
        return (i_Lives == 2'd0) ? 2'd0 : i_Lives - 2'd1;
    endfunction

endpackage

// File: rtl/frogger_game_fsm_if.sv
// ---------------------------------------------------------------------------
// frogger_game_fsm_if
// Groups the game sequencer's inputs (start, VSync, collision, frog row) and
// outputs (state, movement enable, frog reset, lives, score, game over).
//   master : the environment side (drives i_*, observes o_*)
//   slave  : the game sequencer (reads i_*, drives o_*)
// ---------------------------------------------------------------------------
interface frogger_game_fsm_if;
    logic       i_Game_Start;
    logic       i_VSync;
    logic       i_Collided;
    logic [5:0] i_Frogger_Y;
    logic [1:0] o_State;
    logic       o_Game_Active;
    logic       o_Frog_Reset;
    logic [1:0] o_Lives;
    logic [6:0] o_Score;
    logic       o_Game_Over;

    modport master (
        output i_Game_Start, i_VSync, i_Collided, i_Frogger_Y,
        input  o_State, o_Game_Active, o_Frog_Reset, o_Lives, o_Score, o_Game_Over
    );

    modport slave (
        input  i_Game_Start, i_VSync, i_Collided, i_Frogger_Y,
        output o_State, o_Game_Active, o_Frog_Reset, o_Lives, o_Score, o_Game_Over
    );
endinterface

// File: rtl/frogger_game_fsm_rise_edge_det.sv
// ---------------------------------------------------------------------------
// rise_edge_det
// Registered rising-edge detector. o_Pulse is high for one cycle, one cycle
// after the first high sample of i_Sig.
//   i_Clk   : clock
//   i_Rst_n : asynchronous active-low reset
//   i_Sig   : level input (already synchronous to i_Clk)
//   o_Pulse : one-cycle registered pulse
// ---------------------------------------------------------------------------
module rise_edge_det (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Sig,
    output logic o_Pulse
);
    logic r_Sig_Prev;
    logic r_Pulse;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Sig_Prev <= 1'b0;
            r_Pulse    <= 1'b0;
        end else begin
            r_Sig_Prev <= i_Sig;
            r_Pulse    <= i_Sig & ~r_Sig_Prev;
        end
    end

    assign o_Pulse = r_Pulse;
endmodule

// File: rtl/frogger_game_fsm.sv
// ---------------------------------------------------------------------------
// frogger_game_fsm
// Top-level Frogger game sequencer: IDLE / RUNNING / P1_WINS / CLEANUP,
// lives, score, post-collision freeze and win-screen hold.
//   i_Clk    : system clock
//   i_Rst_n  : asynchronous active-low reset, released synchronously
//   io_Game  : slave modport carrying
//              i_Game_Start (debounced level), i_VSync (frame timing),
//              i_Collided (level), i_Frogger_Y (frog tile row),
//              o_State, o_Game_Active, o_Frog_Reset (1-cycle pulse),
//              o_Lives, o_Score (0..99), o_Game_Over
// All outputs are registered.
// ---------------------------------------------------------------------------
module frogger_game_fsm
    import frogger_pkg::*;
#(
    parameter int c_GOAL_ROW    = c_GOAL_ROW_DEFAULT,
    parameter int c_WIN_SCORE   = 5,
    parameter int c_HIT_FRAMES  = 60,
    parameter int c_WIN_FRAMES  = 180,
    parameter int c_START_LIVES = 3
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_n,
    frogger_game_fsm_if.slave    io_Game
);
    localparam logic [1:0]         LP_START_LIVES = 2'(c_START_LIVES);
    localparam logic [6:0]         LP_WIN_SCORE   = 7'(c_WIN_SCORE);
    localparam logic [c_CNT_W-1:0] LP_HIT_FRAMES  = c_CNT_W'(c_HIT_FRAMES);
    localparam logic [c_CNT_W-1:0] LP_WIN_FRAMES  = c_CNT_W'(c_WIN_FRAMES);
    localparam logic [5:0]         LP_GOAL_ROW    = 6'(c_GOAL_ROW);

    t_game_state        r_State,       w_State_Nxt;
    logic [6:0]         r_Score,       w_Score_Nxt;
    logic [1:0]         r_Lives,       w_Lives_Nxt;
    logic               r_Game_Active, w_Game_Active_Nxt;
    logic               r_Frog_Reset,  w_Frog_Reset_Nxt;
    logic               r_Game_Over,   w_Game_Over_Nxt;
    logic [c_CNT_W-1:0] r_Freeze_Cnt,  w_Freeze_Cnt_Nxt;
    logic [c_CNT_W-1:0] r_Frame_Cnt,   w_Frame_Cnt_Nxt;
    logic               r_At_Goal_Prev;

    logic               w_Start_Edge;
    logic               w_Frame_Tick;
    logic               w_At_Goal;
    logic               w_Goal_Edge;
    logic [6:0]         w_Score_Inc;
    logic [c_CNT_W-1:0] w_Frame_Cnt_Inc;

    rise_edge_det u_start_edge (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .i_Sig   (io_Game.i_Game_Start),
        .o_Pulse (w_Start_Edge)
    );

    rise_edge_det u_vsync_edge (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .i_Sig   (io_Game.i_VSync),
        .o_Pulse (w_Frame_Tick)
    );

    assign w_At_Goal       = (io_Game.i_Frogger_Y == LP_GOAL_ROW);
    assign w_Goal_Edge     = w_At_Goal & ~r_At_Goal_Prev;
    assign w_Score_Inc     = f_Score_Inc(r_Score);
    assign w_Frame_Cnt_Inc = r_Frame_Cnt + c_CNT_W'(1);

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_State        <= IDLE;
            r_Score        <= 7'd0;
            r_Lives        <= LP_START_LIVES;
            r_Game_Active  <= 1'b0;
            r_Frog_Reset   <= 1'b0;
            r_Game_Over    <= 1'b0;
            r_Freeze_Cnt   <= '0;
            r_Frame_Cnt    <= '0;
            r_At_Goal_Prev <= 1'b0;
        end else begin
            r_State        <= w_State_Nxt;
            r_Score        <= w_Score_Nxt;
            r_Lives        <= w_Lives_Nxt;
            r_Game_Active  <= w_Game_Active_Nxt;
            r_Frog_Reset   <= w_Frog_Reset_Nxt;
            r_Game_Over    <= w_Game_Over_Nxt;
            r_Freeze_Cnt   <= w_Freeze_Cnt_Nxt;
            r_Frame_Cnt    <= w_Frame_Cnt_Nxt;
            r_At_Goal_Prev <= w_At_Goal;
        end
    end

    always_comb begin
        w_State_Nxt       = r_State;
        w_Score_Nxt       = r_Score;
        w_Lives_Nxt       = r_Lives;
        w_Game_Active_Nxt = r_Game_Active;
        w_Frog_Reset_Nxt  = 1'b0;
        w_Game_Over_Nxt   = r_Game_Over;
        w_Freeze_Cnt_Nxt  = r_Freeze_Cnt;
        w_Frame_Cnt_Nxt   = r_Frame_Cnt;

        case (r_State)
            IDLE: begin
                w_Game_Active_Nxt = 1'b0;
                if (w_Start_Edge) begin
                    w_State_Nxt       = RUNNING;
                    w_Game_Active_Nxt = 1'b1;
                    w_Frog_Reset_Nxt  = 1'b1;
                    w_Game_Over_Nxt   = 1'b0;
                    w_Score_Nxt       = 7'd0;
                    w_Lives_Nxt       = LP_START_LIVES;
                    w_Freeze_Cnt_Nxt  = '0;
                    w_Frame_Cnt_Nxt   = '0;
                end
            end

            RUNNING: begin
                if (r_Game_Active) begin
                    // The cycle right after a frog reset is blanked: the frog
                    // is still being moved to its origin, and skipping it
                    // keeps Frog_Reset from ever being high two cycles in a
                    // row. Collision is a level, so it is seen a cycle later.
                    if (!r_Frog_Reset) begin
                        if (io_Game.i_Collided) begin
                            w_Lives_Nxt       = f_Lives_Dec(r_Lives);
                            w_Frog_Reset_Nxt  = 1'b1;
                            w_Freeze_Cnt_Nxt  = LP_HIT_FRAMES;
                            w_Game_Active_Nxt = 1'b0;
                        end else if (w_Goal_Edge) begin
                            w_Score_Nxt      = w_Score_Inc;
                            w_Frog_Reset_Nxt = 1'b1;
                            if (w_Score_Inc >= LP_WIN_SCORE) begin
                                w_State_Nxt       = P1_WINS;
                                w_Game_Active_Nxt = 1'b0;
                                w_Frame_Cnt_Nxt   = '0;
                            end
                        end
                    end
                end else begin
                    // Frozen after a hit: count frames down, then resume or
                    // end the game once the last life is gone.
                    if (r_Freeze_Cnt == '0) begin
                        if (r_Lives != 2'd0) begin
                            w_Game_Active_Nxt = 1'b1;
                        end else begin
                            w_State_Nxt     = CLEANUP;
                            w_Game_Over_Nxt = 1'b1;
                        end
                    end else if (w_Frame_Tick) begin
                        w_Freeze_Cnt_Nxt = r_Freeze_Cnt - c_CNT_W'(1);
                    end
                end
            end

            P1_WINS: begin
                w_Game_Active_Nxt = 1'b0;
                if (w_Frame_Tick) begin
                    if (w_Frame_Cnt_Inc >= LP_WIN_FRAMES) begin
                        w_State_Nxt = CLEANUP;
                    end else begin
                        w_Frame_Cnt_Nxt = w_Frame_Cnt_Inc;
                    end
                end
            end

            CLEANUP: begin
                // Game_Over deliberately survives into IDLE.
                w_State_Nxt       = IDLE;
                w_Score_Nxt       = 7'd0;
                w_Lives_Nxt       = LP_START_LIVES;
                w_Frog_Reset_Nxt  = 1'b1;
                w_Game_Active_Nxt = 1'b0;
                w_Freeze_Cnt_Nxt  = '0;
                w_Frame_Cnt_Nxt   = '0;
            end

            default: begin
                w_State_Nxt = IDLE;
            end
        endcase
    end

    assign io_Game.o_State       = r_State;
    assign io_Game.o_Score       = r_Score;
    assign io_Game.o_Lives       = r_Lives;
    assign io_Game.o_Game_Active = r_Game_Active;
    assign io_Game.o_Frog_Reset  = r_Frog_Reset;
    assign io_Game.o_Game_Over   = r_Game_Over;

endmodule

// File: tb/tb_frogger_game_fsm.sv
// ---------------------------------------------------------------------------
// tb_frogger_game_fsm
// Directed bench for frogger_game_fsm with short freeze/win timings.
// ---------------------------------------------------------------------------
module tb_frogger_game_fsm;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    frogger_game_fsm_if u_if ();

    frogger_game_fsm #(
        .c_GOAL_ROW    (0),
        .c_WIN_SCORE   (5),
        .c_HIT_FRAMES  (4),
        .c_WIN_FRAMES  (3),
        .c_START_LIVES (3)
    ) u_dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .io_Game (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start edge is registered, FSM acts on the following edge.
    task automatic press_start();
        u_if.i_Game_Start = 1'b1;
        tick(1);
        u_if.i_Game_Start = 1'b0;
        tick(1);
    endtask

    // On return, the resulting frame tick has been consumed by the FSM.
    task automatic vsync_pulse();
        u_if.i_VSync = 1'b1;
        tick(1);
        u_if.i_VSync = 1'b0;
        tick(1);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_state"},  int'(u_if.o_State), 0);
        check_eq({tag, "_score"},  int'(u_if.o_Score), 0);
        check_eq({tag, "_lives"},  int'(u_if.o_Lives), 3);
        check_eq({tag, "_active"}, int'(u_if.o_Game_Active), 0);
        check_eq({tag, "_frst"},   int'(u_if.o_Frog_Reset), 0);
        check_eq({tag, "_gover"},  int'(u_if.o_Game_Over), 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        u_if.i_Game_Start = 1'b0;
        u_if.i_VSync      = 1'b0;
        u_if.i_Collided   = 1'b0;
        u_if.i_Frogger_Y  = 6'd14;

        // Reset state
        tick(2);
        check_reset_vals("rst");
        rst_n = 1'b1;
        tick(2);
        check_eq("idle_hold", int'(u_if.o_State), 0);

        // Start
        press_start();
        check_eq("start_state",  int'(u_if.o_State), 1);
        check_eq("start_frst",   int'(u_if.o_Frog_Reset), 1);
        check_eq("start_active", int'(u_if.o_Game_Active), 1);
        check_eq("start_lives",  int'(u_if.o_Lives), 3);
        check_eq("start_score",  int'(u_if.o_Score), 0);
        tick(1);
        check_eq("start_frst_end", int'(u_if.o_Frog_Reset), 0);
        press_start();
        check_eq("restart_state", int'(u_if.o_State), 1);
        check_eq("restart_frst",  int'(u_if.o_Frog_Reset), 0);

        // Collision held for 10 cycles
        u_if.i_Collided = 1'b1;
        tick(1);
        check_eq("hit_lives",  int'(u_if.o_Lives), 2);
        check_eq("hit_frst",   int'(u_if.o_Frog_Reset), 1);
        check_eq("hit_active", int'(u_if.o_Game_Active), 0);
        tick(9);
        check_eq("hold_lives", int'(u_if.o_Lives), 2);
        check_eq("hold_frst",  int'(u_if.o_Frog_Reset), 0);
        for (int i = 0; i < 3; i++) vsync_pulse();
        check_eq("frz3_active", int'(u_if.o_Game_Active), 0);
        check_eq("frz3_lives",  int'(u_if.o_Lives), 2);
        u_if.i_Collided = 1'b0;
        vsync_pulse();
        check_eq("frz4_active", int'(u_if.o_Game_Active), 0);
        tick(1);
        check_eq("resume_active", int'(u_if.o_Game_Active), 1);
        check_eq("resume_lives",  int'(u_if.o_Lives), 2);

        // Scoring five crossings
        for (int k = 1; k <= 5; k++) begin
            u_if.i_Frogger_Y = 6'd0;
            tick(1);
            check_eq("goal_score", int'(u_if.o_Score), k);
            check_eq("goal_frst",  int'(u_if.o_Frog_Reset), 1);
            check_eq("goal_state", int'(u_if.o_State), (k < 5) ? 1 : 2);
            tick(3);
            check_eq("goal_hold_score", int'(u_if.o_Score), k);
            u_if.i_Frogger_Y = 6'd1;
            tick(1);
        end
        check_eq("win_active", int'(u_if.o_Game_Active), 0);
        vsync_pulse();
        vsync_pulse();
        check_eq("win_state2", int'(u_if.o_State), 2);
        vsync_pulse();
        check_eq("cleanup_state", int'(u_if.o_State), 3);
        check_eq("cleanup_score", int'(u_if.o_Score), 5);
        tick(1);
        check_eq("post_win_state", int'(u_if.o_State), 0);
        check_eq("post_win_score", int'(u_if.o_Score), 0);
        check_eq("post_win_lives", int'(u_if.o_Lives), 3);
        check_eq("post_win_frst",  int'(u_if.o_Frog_Reset), 1);
        check_eq("post_win_gover", int'(u_if.o_Game_Over), 0);
        tick(1);
        check_eq("post_win_frst_end", int'(u_if.o_Frog_Reset), 0);

        // Simultaneous goal edge and collision
        press_start();
        check_eq("g2_state", int'(u_if.o_State), 1);
        tick(1);
        u_if.i_Frogger_Y = 6'd0;
        u_if.i_Collided  = 1'b1;
        tick(1);
        check_eq("both_lives", int'(u_if.o_Lives), 2);
        check_eq("both_score", int'(u_if.o_Score), 0);
        check_eq("both_frst",  int'(u_if.o_Frog_Reset), 1);
        u_if.i_Collided  = 1'b0;
        u_if.i_Frogger_Y = 6'd14;
        tick(1);
        check_eq("both_frst_end", int'(u_if.o_Frog_Reset), 0);
        for (int i = 0; i < 4; i++) vsync_pulse();
        tick(1);
        check_eq("both_resume", int'(u_if.o_Game_Active), 1);

        // Game over: two more hits
        u_if.i_Collided = 1'b1;
        tick(1);
        check_eq("go_lives1", int'(u_if.o_Lives), 1);
        u_if.i_Collided = 1'b0;
        for (int i = 0; i < 4; i++) vsync_pulse();
        tick(1);
        check_eq("go_resume", int'(u_if.o_Game_Active), 1);
        u_if.i_Collided = 1'b1;
        tick(1);
        check_eq("go_lives0", int'(u_if.o_Lives), 0);
        u_if.i_Collided = 1'b0;
        for (int i = 0; i < 4; i++) vsync_pulse();
        check_eq("go_frz_state", int'(u_if.o_State), 1);
        tick(1);
        check_eq("go_cleanup_state", int'(u_if.o_State), 3);
        check_eq("go_cleanup_gover", int'(u_if.o_Game_Over), 1);
        check_eq("go_cleanup_active", int'(u_if.o_Game_Active), 0);
        tick(1);
        check_eq("go_idle_state", int'(u_if.o_State), 0);
        check_eq("go_idle_lives", int'(u_if.o_Lives), 3);
        check_eq("go_idle_gover", int'(u_if.o_Game_Over), 1);
        check_eq("go_idle_frst",  int'(u_if.o_Frog_Reset), 1);
        press_start();
        check_eq("go_restart_state", int'(u_if.o_State), 1);
        check_eq("go_restart_gover", int'(u_if.o_Game_Over), 0);

        // Asynchronous reset mid-freeze
        tick(1);
        u_if.i_Collided = 1'b1;
        tick(1);
        check_eq("mf_active", int'(u_if.o_Game_Active), 0);
        u_if.i_Collided = 1'b0;
        vsync_pulse();
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals("mf_rst");
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check_eq("mf_after_state", int'(u_if.o_State), 0);
        check_eq("mf_after_frst",  int'(u_if.o_Frog_Reset), 0);

        // Asynchronous reset mid-P1_WINS
        press_start();
        tick(1);
        for (int k = 0; k < 5; k++) begin
            u_if.i_Frogger_Y = 6'd0;
            tick(1);
            u_if.i_Frogger_Y = 6'd1;
            tick(2);
        end
        check_eq("mw_state", int'(u_if.o_State), 2);
        check_eq("mw_score", int'(u_if.o_Score), 5);
        vsync_pulse();
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals("mw_rst");
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check_eq("mw_after_state", int'(u_if.o_State), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
